// File: rtl/sync_deglitch_edge.sv
// sync_deglitch_edge
//   Glitch filter and edge detector for an already-synchronized level. The
//   output q only changes after d has held a new value for FILT_CYCLES
//   consecutive clk edges. rise and fall are one-cycle pulses that follow
//   each q transition. There is no combinational path from d to an output.
//
//   Optional feature, macro SYNC_DEGLITCH_CNT_EN:
//     defined   -> cnt is a saturating count of accepted rising edges, and
//                  clr resets it to zero.
//     undefined -> cnt is tied to zero and clr is ignored.
//
// Parameters
//   FILT_CYCLES  number of consecutive samples needed to change q (1..255)
//   RST_VAL      value of q, and the stable state, during and after reset
//   CNT_W        width of cnt (1..32)
//
// Ports
//   clk   in   destination-domain clock, rising edge
//   rst   in   synchronous reset, active high; also overrides clr
//   d     in   synchronized level
//   clr   in   synchronous clear of cnt
//   q     out  filtered level (registered)
//   rise  out  one-cycle pulse in the cycle after q goes 0->1
//   fall  out  one-cycle pulse in the cycle after q goes 1->0
//   cnt   out  saturating count of accepted rising edges
module sync_deglitch_edge #(
  parameter int unsigned FILT_CYCLES = 4,
  parameter bit          RST_VAL     = 1'b0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             clr,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam state_t        RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES);
  localparam bit            FILT_ONE  = (FILT_CYCLES == 1);

  state_t        state, state_n;
  logic [FW-1:0] fcnt, fcnt_n, fcnt_inc;
  logic          go_hi, go_lo;

  // The pending count holds the number of new-value samples seen so far.
  // When the next sample would bring it to FILT_CYCLES, q flips on that
  // same edge.
  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    go_hi    = 1'b0;
    go_lo    = 1'b0;
    fcnt_inc = fcnt + 1'b1;
    case (state)
      STABLE_LO: begin
        if (d) begin
          if (FILT_ONE) begin
            state_n = STABLE_HI;
            go_hi   = 1'b1;
          end else begin
            state_n = PEND_HI;
            fcnt_n  = FW'(1);
          end
        end
      end
      PEND_HI: begin
        if (!d) begin
          // Glitch rejected: q is left alone.
          state_n = STABLE_LO;
          fcnt_n  = '0;
        end else if (fcnt_inc == FILT_LAST) begin
          state_n = STABLE_HI;
          fcnt_n  = '0;
          go_hi   = 1'b1;
        end else begin
          fcnt_n  = fcnt_inc;
        end
      end
      STABLE_HI: begin
        if (!d) begin
          if (FILT_ONE) begin
            state_n = STABLE_LO;
            go_lo   = 1'b1;
          end else begin
            state_n = PEND_LO;
            fcnt_n  = FW'(1);
          end
        end
      end
      PEND_LO: begin
        if (d) begin
          state_n = STABLE_HI;
          fcnt_n  = '0;
        end else if (fcnt_inc == FILT_LAST) begin
          state_n = STABLE_LO;
          fcnt_n  = '0;
          go_lo   = 1'b1;
        end else begin
          fcnt_n  = fcnt_inc;
        end
      end
      default: begin
        state_n = RST_STATE;
        fcnt_n  = '0;
      end
    endcase
  end

  // q, rise and fall all register on the same edge. As a result, the pulse
  // is visible during the cycle that follows the edge on which q changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      fcnt  <= '0;
      q     <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      rise  <= go_hi;
      fall  <= go_lo;
      if (go_hi)      q <= 1'b1;
      else if (go_lo) q <= 1'b0;
    end
  end

`ifdef SYNC_DEGLITCH_CNT_EN
  // Saturating count of accepted rises. When clr and an increment happen
  // on the same edge, clr takes priority.
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (clr)                           cnt <= '0;
    else if (go_hi && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
  end
`else
  assign cnt = '0;
  logic unused_clr;
  assign unused_clr = clr;
`endif

endmodule
